music_player: RTL and testbench

Sequencer and tone generator that reads the song ROM. It steps a 7-bit address through the song at a fixed beat rate and takes the half-period count returned for each address. From that count it produces a square-wave buzzer drive. It sits between the user controls and the board buzzer pin, driving the ROM address port and consuming the ROM note word.

---
 rtl/music_pkg.sv | 36 +++
 rtl/music_player_tone_gen.sv | 43 ++++
 rtl/music_player.sv | 120 ++++++++++++
 tb/tb_music_player.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music player: note half-period table, FSM
// state encoding and the rest code that marks a silent ROM entry.
package music_pkg;

  localparam int NOTE_W_DEF    = 20;
  localparam int REST_CODE_DEF = 2500;

  // Half-periods in 50 MHz clk cycles (50e6 / (2 * f_note)).
  localparam logic [NOTE_W_DEF-1:0] D5  = 20'd127551;  // G3
  localparam logic [NOTE_W_DEF-1:0] D6  = 20'd113636;  // A3
  localparam logic [NOTE_W_DEF-1:0] D7  = 20'd101215;  // B3
  localparam logic [NOTE_W_DEF-1:0] M1  = 20'd95420;   // C4
  localparam logic [NOTE_W_DEF-1:0] M2  = 20'd85034;   // D4
  localparam logic [NOTE_W_DEF-1:0] M3  = 20'd75758;   // E4
  localparam logic [NOTE_W_DEF-1:0] M4  = 20'd71633;   // F4
  localparam logic [NOTE_W_DEF-1:0] M5  = 20'd63776;   // G4
  localparam logic [NOTE_W_DEF-1:0] M6  = 20'd56818;   // A4
  localparam logic [NOTE_W_DEF-1:0] M7  = 20'd50607;   // B4
  localparam logic [NOTE_W_DEF-1:0] H1  = 20'd47801;   // C5
  localparam logic [NOTE_W_DEF-1:0] H2  = 20'd42589;   // D5
  localparam logic [NOTE_W_DEF-1:0] H3  = 20'd37936;   // E5
  localparam logic [NOTE_W_DEF-1:0] H4  = 20'd35817;   // F5
  localparam logic [NOTE_W_DEF-1:0] H5  = 20'd31888;   // G5
  localparam logic [NOTE_W_DEF-1:0] H6  = 20'd28409;   // A5
  localparam logic [NOTE_W_DEF-1:0] H7  = 20'd25304;   // B5
  localparam logic [NOTE_W_DEF-1:0] HH1 = 20'd23878;   // C6
  localparam logic [NOTE_W_DEF-1:0] HH2 = 20'd21277;   // D6
  localparam logic [NOTE_W_DEF-1:0] S   = 20'd2500;    // rest

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_PLAY  = 2'd3;

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave tone generator: a half-period counter that flips an internal
// phase bit every note_r enabled cycles. The output is gated so that the
// phase keeps advancing even while the buzzer is held silent.
module tone_gen
  import music_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note_r,
  input  logic              clear,
  input  logic              enable,
  input  logic              force_low,
  output logic              buzzer
);

  localparam logic [NOTE_W-1:0] ONE = NOTE_W'(1);

  logic [NOTE_W-1:0] tone_cnt;
  logic              phase;

  // Half-period counter; wraps and flips the phase at note_r-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (clear) begin
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (enable) begin
      if (tone_cnt == note_r - ONE) begin
        tone_cnt <= '0;
        phase    <= ~phase;
      end else begin
        tone_cnt <= tone_cnt + ONE;
      end
    end
  end

  assign buzzer = phase & enable & ~force_low;

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the ROM address once per beat, loads each note word
// and drives tone_gen with it. Handles start/stop/pause/loop controls.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | stopped, buzzer silent, rom_addr holds last value
// FETCH    | rom_addr just changed, waiting one cycle for ROM data
// LOAD     | capture note word, clear beat and tone counters
// PLAY     | beat counter running, tone generator active
module music_player
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 250_000,
  parameter int SONG_LEN    = 128,
  parameter int ADDR_W      = 7,
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter logic [NOTE_W-1:0] REST_CODE = NOTE_W'(REST_CODE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic              buzzer,
  output logic              playing,
  output logic              done
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  // One extra bit so a zero-length gap (start == BEAT_CYCLES) cannot alias.
  localparam logic [BEAT_W:0]   GAP_START = (BEAT_W+1)'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [1:0]        state;
  logic [NOTE_W-1:0] note_r;
  logic [BEAT_W-1:0] beat_cnt;
  logic              tone_clear;
  logic              tone_en;
  logic              force_low;

  // Sequencer FSM, beat counter, address stepping and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      note_r   <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_FETCH;
              rom_addr <= '0;
            end
          end
          ST_FETCH: begin
            if (!pause) state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (!pause) begin
              note_r   <= rom_note;
              beat_cnt <= '0;
              state    <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (!pause) begin
              if (beat_cnt == BEAT_LAST) begin
                if (rom_addr < LAST_ADDR) begin
                  rom_addr <= rom_addr + ADDR_ONE;
                  state    <= ST_FETCH;
                end else if (loop_en) begin
                  rom_addr <= '0;
                  state    <= ST_FETCH;
                end else begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end
              end else begin
                beat_cnt <= beat_cnt + BEAT_ONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign playing    = (state != ST_IDLE);
  assign tone_clear = (state == ST_LOAD);
  assign tone_en    = (state == ST_PLAY) && !pause;
  assign force_low  = (note_r == '0) || (note_r == REST_CODE) ||
                      ({1'b0, beat_cnt} >= GAP_START);

  tone_gen #(
    .NOTE_W (NOTE_W)
  ) u_tone_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_r    (note_r),
    .clear     (tone_clear),
    .enable    (tone_en),
    .force_low (force_low),
    .buzzer    (buzzer)
  );

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player with a short song and a beat-level reference model.
module tb_music_player;

  localparam int B  = 40;
  localparam int G  = 4;
  localparam int L  = 4;
  localparam int AW = 7;
  localparam int NW = 20;
  localparam int REST = 2500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [NW-1:0] rom_note;
  logic          buzzer;
  logic          playing;
  logic          done;

  int rom_tbl [4] = '{6, 2500, 10, 0};

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Model: busy flag, position within an address (0 fetch, 1 load, 2 play),
  // current address, and number of active play cycles elapsed in the beat.
  bit m_busy;
  int m_ph;
  int m_addr;
  int m_k;
  bit m_done;

  always #5 clk = ~clk;

  // Stub song ROM with one cycle of read latency.
  always @(posedge clk) rom_note <= NW'(rom_tbl[rom_addr[1:0]]);

  music_player #(
    .BEAT_CYCLES (B),
    .GAP_CYCLES  (G),
    .SONG_LEN    (L),
    .ADDR_W      (AW),
    .NOTE_W      (NW),
    .REST_CODE   (20'd2500)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_note (rom_note),
    .buzzer   (buzzer),
    .playing  (playing),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_buzz();
    int n;
    if (!m_busy || m_ph != 2 || pause) return 0;
    n = rom_tbl[m_addr];
    if (n == 0 || n == REST || m_k >= B - G) return 0;
    return (m_k / n) % 2;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ph = 0; m_addr = 0; m_k = 0; m_done = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_ph = 0; m_addr = 0;
      end
    end else if (!pause) begin
      if (m_ph == 0) begin
        m_ph = 1;
      end else if (m_ph == 1) begin
        m_ph = 2; m_k = 0;
      end else if (m_k == B - 1) begin
        if (m_addr < L - 1) begin
          m_addr++; m_ph = 0;
        end else if (loop_en) begin
          m_addr = 0; m_ph = 0;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic check_outputs();
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("playing", 32'(playing), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("buzzer", 32'(buzzer), 32'(exp_buzz()));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int n;
    model_reset();

    // Reset, then idle with no start.
    run(3);
    rst_n = 1'b1;
    run(12);

    // Full song without loop: one done pulse.
    done_cnt = 0;
    loop_en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    run(4 * (B + 2) + 6);
    check("done_count", 32'(done_cnt), 32'd1);

    // Looping playback, then stop mid-play.
    done_cnt = 0;
    loop_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    run(4 * (B + 2) + 10);
    check("loop_no_done", 32'(done_cnt), 32'd0);
    check("loop_addr", 32'(rom_addr), 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;
    run(5);
    check("stop_no_done", 32'(done_cnt), 32'd0);
    loop_en = 1'b0;

    // Pause 20 cycles mid-beat: address step arrives 20 cycles late.
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    run(12); n += 12;
    pause = 1'b1; run(20); n += 20;
    pause = 1'b0;
    while (rom_addr != 1 && n < 200) begin
      cyc(); n++;
    end
    check("pause_delay", 32'(n), 32'd62);
    stop = 1'b1; cyc(); stop = 1'b0;
    run(3);

    // start and stop together: stays idle.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    run(4);

    // Asynchronous reset mid-play.
    start = 1'b1; cyc(); start = 1'b0;
    run(20);
    rst_n = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(5);

    // Randomized controls.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      if (pause) pause = ($urandom_range(0, 7) != 0);
      else pause = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = 1'($urandom);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      cyc();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; rst_n = 1'b1;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
